// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Round-robin arbiter that shares one single-port data RAM between port 0
//   (processor load/store) and port 1 (I/O / DMA). At most one request is
//   granted per cycle. Read data returns one cycle after the grant, tagged by
//   port. A per-port lock holds ownership for atomic read-modify-write, and
//   addresses at or above MEM_DEPTH are range-checked.
//
//   Ports
//     clock, reset             rising-edge clock, synchronous active-high reset
//     request0/1               access request, held with its fields until granted
//     writeEnable0/1           1 = write, 0 = read
//     address0/1, dataIn0/1    word address and write data
//     lock0/1                  keep ownership after this grant
//     grant0/1                 access issued this cycle (combinational)
//     readValid0/1             read data valid this cycle (registered)
//     readData0/1              read result, 0 when not valid
//     ramAddress, ramDataC,
//     ramWriteEnable           RAM address, write data and write enable
//     ramDataOutput            RAM read data (address registered last edge)
//     addressError             one-cycle pulse after an out-of-range grant
module data_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MEM_DEPTH  = 21
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  request0,
  input  logic                  request1,
  input  logic                  writeEnable0,
  input  logic                  writeEnable1,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0] dataIn0,
  input  logic [DATA_WIDTH-1:0] dataIn1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  readValid0,
  output logic                  readValid1,
  output logic [DATA_WIDTH-1:0] readData0,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramDataC,
  output logic                  ramWriteEnable,
  input  logic [DATA_WIDTH-1:0] ramDataOutput,
  output logic                  addressError
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  read_valid0_q, read_valid0_d;
  logic                  read_valid1_q, read_valid1_d;
  logic                  err_tag_q, err_tag_d;
  logic                  address_error_q, address_error_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

  logic                  any_grant;
  logic                  sel_we;
  logic                  sel_in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  in_range0;
  logic                  in_range1;

  always_comb begin
    in_range0 = ({1'b0, address0} < MEM_LIMIT);
    in_range1 = ({1'b0, address1} < MEM_LIMIT);
  end

  // Grant selection. On a tie in FREE, last_grant_q == 1 means port 0 wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state_q)
        FREE: begin
          if (request0 && request1) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
          end else begin
            grant0 = request0;
            grant1 = request1;
          end
        end
        LOCK0:   grant0 = request0;
        LOCK1:   grant1 = request1;
        default: ;
      endcase
    end
  end

  // RAM side: follow the winner; on idle cycles hold the last granted
  // address so a read issued last cycle is not disturbed.
  always_comb begin
    any_grant    = grant0 | grant1;
    sel_we       = grant1 ? writeEnable1 : writeEnable0;
    sel_in_range = grant1 ? in_range1    : in_range0;
    sel_addr     = grant1 ? address1     : address0;
    sel_data     = grant1 ? dataIn1      : dataIn0;

    ramAddress     = any_grant ? sel_addr : ram_addr_q;
    ramDataC       = any_grant ? sel_data : '0;
    ramWriteEnable = any_grant && sel_we && sel_in_range && !reset;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (grant0 && lock0)      state_d = LOCK0;
        else if (grant1 && lock1) state_d = LOCK1;
      end
      LOCK0: if (!request0 || (grant0 && !lock0)) state_d = FREE;
      LOCK1: if (!request1 || (grant1 && !lock1)) state_d = FREE;
      default: state_d = FREE;
    endcase

    last_grant_d    = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_grant_q);
    ram_addr_d      = any_grant ? sel_addr : ram_addr_q;
    read_valid0_d   = grant0 && !writeEnable0;
    read_valid1_d   = grant1 && !writeEnable1;
    // Out-of-range reads still complete but return zero data.
    err_tag_d       = any_grant && !sel_we && !sel_in_range;
    address_error_d = any_grant && !sel_in_range;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= FREE;
      last_grant_q    <= 1'b1;
      read_valid0_q   <= 1'b0;
      read_valid1_q   <= 1'b0;
      err_tag_q       <= 1'b0;
      address_error_q <= 1'b0;
      ram_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      read_valid0_q   <= read_valid0_d;
      read_valid1_q   <= read_valid1_d;
      err_tag_q       <= err_tag_d;
      address_error_q <= address_error_d;
      ram_addr_q      <= ram_addr_d;
    end
  end

  always_comb begin
    readValid0   = read_valid0_q;
    readValid1   = read_valid1_q;
    readData0    = (read_valid0_q && !err_tag_q) ? ramDataOutput : '0;
    readData1    = (read_valid1_q && !err_tag_q) ? ramDataOutput : '0;
    addressError = address_error_q;
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

  localparam logic [31:0] C3  = 32'h3333_3333;
  localparam logic [31:0] C7  = 32'h7777_7777;
  localparam logic [31:0] A5  = 32'hA5A5_A5A5;
  localparam logic [31:0] WD  = 32'h1234_5678;
  localparam logic [31:0] FF  = 32'hFFFF_FFFF;

  logic        clock;
  logic        reset;
  logic        request0, request1, writeEnable0, writeEnable1, lock0, lock1;
  logic [9:0]  address0, address1;
  logic [31:0] dataIn0, dataIn1;
  logic        grant0, grant1, readValid0, readValid1;
  logic [31:0] readData0, readData1;
  logic [9:0]  ramAddress;
  logic [31:0] ramDataC;
  logic        ramWriteEnable;
  logic [31:0] ramDataOutput;
  logic        addressError;

  logic [31:0] mem [0:1023];

  int n_cmp;
  int n_fail;

  data_ram_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .MEM_DEPTH (21)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .request0      (request0),
    .request1      (request1),
    .writeEnable0  (writeEnable0),
    .writeEnable1  (writeEnable1),
    .address0      (address0),
    .address1      (address1),
    .dataIn0       (dataIn0),
    .dataIn1       (dataIn1),
    .lock0         (lock0),
    .lock1         (lock1),
    .grant0        (grant0),
    .grant1        (grant1),
    .readValid0    (readValid0),
    .readValid1    (readValid1),
    .readData0     (readData0),
    .readData1     (readData1),
    .ramAddress    (ramAddress),
    .ramDataC      (ramDataC),
    .ramWriteEnable(ramWriteEnable),
    .ramDataOutput (ramDataOutput),
    .addressError  (addressError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM model.
  always @(posedge clock) begin
    if (ramWriteEnable) mem[ramAddress] <= ramDataC;
    ramDataOutput <= mem[ramAddress];
  end

  typedef struct {
    logic        rst, r0, w0, l0, r1, w1, l1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        g0, g1, rv0, rv1, rwe, aerr;
    logic [31:0] rd0, rd1;
    logic [9:0]  raddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst,
    input logic r0, input logic w0, input logic l0, input logic [9:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic l1, input logic [9:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1,
    input logic rv0, input logic [31:0] rd0, input logic rv1, input logic [31:0] rd1,
    input logic rwe, input logic aerr, input logic [9:0] raddr);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    v.rwe = rwe; v.aerr = aerr; v.raddr = raddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    request0     = v.r0; writeEnable0 = v.w0; lock0 = v.l0; address0 = v.a0; dataIn0 = v.d0;
    request1     = v.r1; writeEnable1 = v.w1; lock1 = v.l1; address1 = v.a1; dataIn1 = v.d1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_mem;
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[3] = C3;
    mem[5] = A5;
    mem[7] = C7;

    drive(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0, 0));
    next_cycle();

    //         rst  r0 w0 l0 a0  d0   r1 w1 l1 a1  d1   g0 g1 rv0 rd0  rv1 rd1  rwe ae addr
    vecs.push_back(mk(1, 1,0,0,5,0,   0,0,0,0,0,   0,0, 0,0,   0,0,   0,0, 0));
    vecs.push_back(mk(1, 1,0,0,3,0,   1,0,0,7,0,   0,0, 0,0,   0,0,   0,0, 0));
    vecs.push_back(mk(0, 1,0,0,3,0,   1,0,0,7,0,   1,0, 0,0,   0,0,   0,0, 3));
    vecs.push_back(mk(0, 1,0,0,3,0,   1,0,0,7,0,   0,1, 1,C3,  0,0,   0,0, 7));
    vecs.push_back(mk(0, 1,0,0,3,0,   1,0,0,7,0,   1,0, 0,0,   1,C7,  0,0, 3));
    vecs.push_back(mk(0, 1,0,0,3,0,   1,0,0,7,0,   0,1, 1,C3,  0,0,   0,0, 7));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 0,0,   1,C7,  0,0, 7));
    vecs.push_back(mk(0, 1,0,0,5,0,   0,0,0,0,0,   1,0, 0,0,   0,0,   0,0, 5));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 1,A5,  0,0,   0,0, 5));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,0,20,WD, 0,1, 0,0,   0,0,   1,0, 20));
    vecs.push_back(mk(0, 1,0,0,20,0,  0,0,0,0,0,   1,0, 0,0,   0,0,   0,0, 20));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 1,WD,  0,0,   0,0, 20));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,0,0,7,0,   0,1, 0,0,   0,0,   0,0, 7));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 0,0,   1,C7,  0,0, 7));
    vecs.push_back(mk(0, 1,0,1,5,0,   1,0,0,7,0,   1,0, 0,0,   0,0,   0,0, 5));
    vecs.push_back(mk(0, 1,0,1,5,0,   1,0,0,7,0,   1,0, 1,A5,  0,0,   0,0, 5));
    vecs.push_back(mk(0, 1,0,0,5,0,   1,0,0,7,0,   1,0, 1,A5,  0,0,   0,0, 5));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,0,0,7,0,   0,1, 1,A5,  0,0,   0,0, 7));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 0,0,   1,C7,  0,0, 7));
    vecs.push_back(mk(0, 1,0,1,5,0,   0,0,0,0,0,   1,0, 0,0,   0,0,   0,0, 5));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,0,0,7,0,   0,0, 1,A5,  0,0,   0,0, 5));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,0,0,7,0,   0,1, 0,0,   0,0,   0,0, 7));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 0,0,   1,C7,  0,0, 7));
    vecs.push_back(mk(0, 1,1,0,21,FF, 0,0,0,0,0,   1,0, 0,0,   0,0,   0,0, 21));
    vecs.push_back(mk(0, 1,0,0,21,0,  0,0,0,0,0,   1,0, 0,0,   0,0,   0,1, 21));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 1,0,   0,0,   0,1, 21));
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0, 0,0,   0,0,   0,0, 21));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #3;
      chk($sformatf("row%0d grant0", i), 32'(grant0), 32'(vecs[i].g0));
      chk($sformatf("row%0d grant1", i), 32'(grant1), 32'(vecs[i].g1));
      chk($sformatf("row%0d readValid0", i), 32'(readValid0), 32'(vecs[i].rv0));
      chk($sformatf("row%0d readData0", i), readData0, vecs[i].rd0);
      chk($sformatf("row%0d readValid1", i), 32'(readValid1), 32'(vecs[i].rv1));
      chk($sformatf("row%0d readData1", i), readData1, vecs[i].rd1);
      chk($sformatf("row%0d ramWriteEnable", i), 32'(ramWriteEnable), 32'(vecs[i].rwe));
      chk($sformatf("row%0d addressError", i), 32'(addressError), 32'(vecs[i].aerr));
      chk($sformatf("row%0d ramAddress", i), 32'(ramAddress), 32'(vecs[i].raddr));
      if (vecs[i].rwe) chk($sformatf("row%0d ramDataC", i), ramDataC, vecs[i].d1);
      next_cycle();
    end

    // Out-of-range write must not touch the implemented words or word 21.
    for (int i = 0; i <= 21; i++) begin
      exp_mem = 32'hC0DE_0000 + 32'(i);
      if (i == 3)  exp_mem = C3;
      if (i == 5)  exp_mem = A5;
      if (i == 7)  exp_mem = C7;
      if (i == 20) exp_mem = WD;
      chk($sformatf("mem[%0d]", i), mem[i], exp_mem);
    end

    // Reset asserted the cycle after a read grant; lastGrant was 0 beforehand.
    drive(mk(0, 1,0,0,5,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0, 0));
    #3;
    chk("rst_seq grant0", 32'(grant0), 32'd1);
    next_cycle();
    drive(mk(1, 1,0,0,5,0, 1,0,0,7,0, 0,0, 0,0,0,0, 0,0, 0));
    #3;
    chk("rst_seq grant0 in reset", 32'(grant0), 32'd0);
    chk("rst_seq grant1 in reset", 32'(grant1), 32'd0);
    chk("rst_seq ramWriteEnable in reset", 32'(ramWriteEnable), 32'd0);
    next_cycle();
    drive(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0, 0));
    #3;
    chk("rst_seq readValid0 after", 32'(readValid0), 32'd0);
    chk("rst_seq readData0 after", readData0, 32'd0);
    chk("rst_seq readValid1 after", 32'(readValid1), 32'd0);
    chk("rst_seq addressError after", 32'(addressError), 32'd0);
    chk("rst_seq ramAddress after", 32'(ramAddress), 32'd0);
    next_cycle();
    drive(mk(0, 1,0,0,3,0, 1,0,0,7,0, 0,0, 0,0,0,0, 0,0, 0));
    #3;
    chk("rst_seq first tie grant0", 32'(grant0), 32'd1);
    chk("rst_seq first tie grant1", 32'(grant1), 32'd0);
    next_cycle();
    drive(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0, 0));
    #3;
    chk("rst_seq tie readValid0", 32'(readValid0), 32'd1);
    chk("rst_seq tie readData0", readData0, C3);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
